miriscv_lsu_resp_tracker: RTL and testbench

//  Tracks up to DEPTH outstanding data-memory requests and pairs in-order data_rvalid_i responses with stored metadata.

---
 rtl/miriscv_lsu_resp_tracker_pkg.sv | 42 ++++
 rtl/miriscv_lsu_resp_tracker_if.sv | 38 +++
 rtl/miriscv_lsu_resp_tracker_load_align.sv | 47 ++++
 rtl/miriscv_lsu_resp_tracker.sv | 148 ++++++++++++++
 tb/tb_miriscv_lsu_resp_tracker.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/miriscv_lsu_resp_tracker_pkg.sv
// Shared types for the LSU response tracker: access-size codes,
// the outstanding-request entry and the alignment rule.
package miriscv_lsu_resp_tracker_pkg;

   localparam int MEM_ACCESS_W = 3;

   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd0;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd2;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DWORD = 3'd3;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd4;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd5;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UWORD = 3'd6;

   // Byte offset held at the widest supported width (XLEN=64).
   localparam int LSB_MAX_W = 3;

   typedef struct packed {
      logic                    we;
      logic [MEM_ACCESS_W-1:0] size;
      logic [LSB_MAX_W-1:0]    addr_lsb;
      logic                    discard;
   } lsu_pend_t;

   // HALF at offset 1 stays legal: it never leaves the 32-bit word.
   function automatic logic lsu_is_aligned(
      input logic [MEM_ACCESS_W-1:0] size,
      input logic [LSB_MAX_W-1:0]    lsb
   );
      logic ok;
      case (size)
         MEM_ACCESS_DWORD: ok = (lsb == 3'd0);
         MEM_ACCESS_WORD,
         MEM_ACCESS_UWORD: ok = (lsb[1:0] == 2'd0);
         MEM_ACCESS_HALF,
         MEM_ACCESS_UHALF: ok = (lsb[1:0] != 2'd3);
         default:          ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/miriscv_lsu_resp_tracker_if.sv
// Request/response bundle between the M/MP stages, the data bus
// and the response tracker.
interface miriscv_lsu_resp_tracker_if
   import miriscv_lsu_resp_tracker_pkg::*;
#(
   parameter int XLEN = 32
);
   localparam int ADDR_LSB_W = $clog2(XLEN/8);

   logic                    req_push_i;
   logic                    req_we_i;
   logic [MEM_ACCESS_W-1:0] req_size_i;
   logic [ADDR_LSB_W-1:0]   req_addr_lsb_i;
   logic                    req_ready_o;

   logic                    data_rvalid_i;
   logic [XLEN-1:0]         data_rdata_i;

   logic                    resp_valid_o;
   logic                    resp_we_o;
   logic [XLEN-1:0]         resp_data_o;
   logic                    resp_misalign_o;

   modport master (
      output req_push_i, req_we_i, req_size_i, req_addr_lsb_i,
      output data_rvalid_i, data_rdata_i,
      input  req_ready_o,
      input  resp_valid_o, resp_we_o, resp_data_o, resp_misalign_o
   );

   modport slave (
      input  req_push_i, req_we_i, req_size_i, req_addr_lsb_i,
      input  data_rvalid_i, data_rdata_i,
      output req_ready_o,
      output resp_valid_o, resp_we_o, resp_data_o, resp_misalign_o
   );

endinterface

// File: rtl/miriscv_lsu_resp_tracker_load_align.sv
// Extracts and sign/zero-extends a load from the raw bus word,
// flagging offsets the access size cannot reach.
module miriscv_lsu_load_align
   import miriscv_lsu_resp_tracker_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic [MEM_ACCESS_W-1:0] size_i,
   input  logic [LSB_MAX_W-1:0]    addr_lsb_i,
   input  logic [XLEN-1:0]         rdata_i,
   output logic [XLEN-1:0]         data_o,
   output logic                    misalign_o
);

   localparam logic [LSB_MAX_W-1:0] LSB_MASK = LSB_MAX_W'(XLEN/8 - 1);

   logic [LSB_MAX_W-1:0] lsb;
   logic [XLEN-1:0]      sh;
   logic [XLEN-1:0]      ext;
   logic                 known;
   logic                 aligned;

   always_comb begin
      lsb     = addr_lsb_i & LSB_MASK;
      sh      = rdata_i >> {lsb, 3'b000};
      ext     = '0;
      known   = 1'b1;
      aligned = lsu_is_aligned(size_i, lsb);
      case (size_i)
         MEM_ACCESS_BYTE:  ext = XLEN'($signed(sh[7:0]));
         MEM_ACCESS_UBYTE: ext = XLEN'(sh[7:0]);
         MEM_ACCESS_HALF:  ext = XLEN'($signed(sh[15:0]));
         MEM_ACCESS_UHALF: ext = XLEN'(sh[15:0]);
         MEM_ACCESS_WORD:  ext = XLEN'($signed(sh[31:0]));
         MEM_ACCESS_UWORD: ext = XLEN'(sh[31:0]);
         MEM_ACCESS_DWORD: begin
            // Doubleword only exists on a 64-bit bus.
            if (XLEN == 64) ext = sh;
            else known = 1'b0;
         end
         default: known = 1'b0;
      endcase
      misalign_o = known & ~aligned;
      data_o     = (known & aligned) ? ext : '0;
   end

endmodule

// File: rtl/miriscv_lsu_resp_tracker.sv
// In-order tracker for outstanding data-bus requests; pairs each
// rvalid with its request metadata and delivers the load result.
module miriscv_lsu_resp_tracker
   import miriscv_lsu_resp_tracker_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 4,
   parameter int REG_RESP = 0
)(
   input  logic                     clk_i,
   input  logic                     arstn_i,
   miriscv_lsu_resp_tracker_if.slave bus_if,
   input  logic                     cu_kill_i,
   output logic [$clog2(DEPTH):0]   pend_cnt_o,
   output logic                     empty_o,
   output logic                     err_unexp_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   lsu_pend_t          fifo_q [DEPTH];
   lsu_pend_t          fifo_d [DEPTH];
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               push;
   logic               pop;
   lsu_pend_t          head;

   logic               rsp_valid;
   logic               rsp_we;
   logic [XLEN-1:0]    rsp_data;
   logic               rsp_mis;
   logic [XLEN-1:0]    ld_data;
   logic               ld_mis;

   assign bus_if.req_ready_o = (cnt_q != FULL);
   assign empty_o            = (cnt_q == '0);
   assign pend_cnt_o         = cnt_q;

   assign push = bus_if.req_push_i & bus_if.req_ready_o;
   assign pop  = bus_if.data_rvalid_i & ~empty_o;
   assign head = fifo_q[rptr_q];

   assign err_unexp_o = bus_if.data_rvalid_i & empty_o;

   always_comb begin
      fifo_d = fifo_q;
      // Marking free slots too is harmless: a push overwrites them.
      if (cu_kill_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i].discard = 1'b1;
         end
      end
      if (push) begin
         fifo_d[wptr_q] = '{
            we:       bus_if.req_we_i,
            size:     bus_if.req_size_i,
            addr_lsb: LSB_MAX_W'(bus_if.req_addr_lsb_i),
            discard:  cu_kill_i
         };
      end
      wptr_d = wptr_q + PTR_W'(push);
      rptr_d = rptr_q + PTR_W'(pop);
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         fifo_q <= fifo_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   miriscv_lsu_load_align #(
      .XLEN (XLEN)
   ) u_align (
      .size_i     (head.size),
      .addr_lsb_i (head.addr_lsb),
      .rdata_i    (bus_if.data_rdata_i),
      .data_o     (ld_data),
      .misalign_o (ld_mis)
   );

   always_comb begin
      rsp_valid = pop & ~head.discard & ~cu_kill_i;
      rsp_we    = rsp_valid & head.we;
      rsp_data  = (rsp_valid & ~head.we) ? ld_data : '0;
      rsp_mis   = rsp_valid & ~head.we & ld_mis;
   end

   generate
      if (REG_RESP != 0) begin : g_reg_resp
         logic            valid_q;
         logic            we_q;
         logic [XLEN-1:0] data_q;
         logic            mis_q;

         always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
               valid_q <= 1'b0;
               we_q    <= 1'b0;
               data_q  <= '0;
               mis_q   <= 1'b0;
            end else if (cu_kill_i) begin
               valid_q <= 1'b0;
               we_q    <= 1'b0;
               data_q  <= '0;
               mis_q   <= 1'b0;
            end else begin
               valid_q <= rsp_valid;
               we_q    <= rsp_we;
               data_q  <= rsp_data;
               mis_q   <= rsp_mis;
            end
         end

         assign bus_if.resp_valid_o    = valid_q;
         assign bus_if.resp_we_o       = we_q;
         assign bus_if.resp_data_o     = data_q;
         assign bus_if.resp_misalign_o = mis_q;
      end else begin : g_comb_resp
         assign bus_if.resp_valid_o    = rsp_valid;
         assign bus_if.resp_we_o       = rsp_we;
         assign bus_if.resp_data_o     = rsp_data;
         assign bus_if.resp_misalign_o = rsp_mis;
      end
   endgenerate

   // The requester must honour req_ready_o; an overflow push is dropped.
   a_no_push_when_full: assert property (
      @(posedge clk_i) disable iff (!arstn_i)
      !(bus_if.req_push_i && !bus_if.req_ready_o)
   );

endmodule

// File: tb/tb_miriscv_lsu_resp_tracker.sv
// Directed bench: 32-bit comb, 64-bit comb and 32-bit registered
// response trackers driven through hand-computed vectors.
module tb_miriscv_lsu_resp_tracker;
   import miriscv_lsu_resp_tracker_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   miriscv_lsu_resp_tracker_if #(.XLEN(32)) a_if ();
   miriscv_lsu_resp_tracker_if #(.XLEN(64)) b_if ();
   miriscv_lsu_resp_tracker_if #(.XLEN(32)) c_if ();

   logic       a_kill, b_kill, c_kill;
   logic [2:0] a_cnt, b_cnt, c_cnt;
   logic       a_empty, b_empty, c_empty;
   logic       a_err, b_err, c_err;

   miriscv_lsu_resp_tracker #(.XLEN(32), .DEPTH(4), .REG_RESP(0)) u_a (
      .clk_i(clk), .arstn_i(rst_n), .bus_if(a_if), .cu_kill_i(a_kill),
      .pend_cnt_o(a_cnt), .empty_o(a_empty), .err_unexp_o(a_err)
   );
   miriscv_lsu_resp_tracker #(.XLEN(64), .DEPTH(4), .REG_RESP(0)) u_b (
      .clk_i(clk), .arstn_i(rst_n), .bus_if(b_if), .cu_kill_i(b_kill),
      .pend_cnt_o(b_cnt), .empty_o(b_empty), .err_unexp_o(b_err)
   );
   miriscv_lsu_resp_tracker #(.XLEN(32), .DEPTH(4), .REG_RESP(1)) u_c (
      .clk_i(clk), .arstn_i(rst_n), .bus_if(c_if), .cu_kill_i(c_kill),
      .pend_cnt_o(c_cnt), .empty_o(c_empty), .err_unexp_o(c_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      a_if.req_push_i = 0; a_if.req_we_i = 0; a_if.req_size_i = '0;
      a_if.req_addr_lsb_i = '0; a_if.data_rvalid_i = 0; a_kill = 0;
      b_if.req_push_i = 0; b_if.req_we_i = 0; b_if.req_size_i = '0;
      b_if.req_addr_lsb_i = '0; b_if.data_rvalid_i = 0; b_kill = 0;
      c_if.req_push_i = 0; c_if.req_we_i = 0; c_if.req_size_i = '0;
      c_if.req_addr_lsb_i = '0; c_if.data_rvalid_i = 0; c_kill = 0;
   endtask

   task automatic a_req(input logic we, input logic [2:0] sz,
                        input logic [1:0] lsb);
      a_if.req_push_i = 1; a_if.req_we_i = we;
      a_if.req_size_i = sz; a_if.req_addr_lsb_i = lsb;
   endtask

   task automatic b_req(input logic [2:0] sz, input logic [2:0] lsb);
      b_if.req_push_i = 1; b_if.req_we_i = 0;
      b_if.req_size_i = sz; b_if.req_addr_lsb_i = lsb;
   endtask

   task automatic c_req(input logic [2:0] sz, input logic [1:0] lsb);
      c_if.req_push_i = 1; c_if.req_we_i = 0;
      c_if.req_size_i = sz; c_if.req_addr_lsb_i = lsb;
   endtask

   task automatic a_rv(input logic [31:0] d);
      a_if.data_rvalid_i = 1; a_if.data_rdata_i = d;
   endtask

   task automatic step();
      @(negedge clk);
      idle_all();
   endtask

   initial begin
      idle_all();
      a_if.data_rdata_i = '0;
      b_if.data_rdata_i = '0;
      c_if.data_rdata_i = '0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_a_empty", a_empty, 1);
      chk("rst_a_ready", a_if.req_ready_o, 1);
      chk("rst_a_valid", a_if.resp_valid_o, 0);
      chk("rst_a_data", a_if.resp_data_o, 0);
      chk("rst_a_we", a_if.resp_we_o, 0);
      chk("rst_a_mis", a_if.resp_misalign_o, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_b_empty", b_empty, 1);
      chk("rst_c_valid", c_if.resp_valid_o, 0);
      step(); rst_n = 1;

      // LB at offset 3 sign-extends the top byte
      step(); a_req(0, MEM_ACCESS_BYTE, 2'd3); #1;
      chk("t1_cnt0", a_cnt, 0);
      step(); a_rv(32'h80FF_0000); #1;
      chk("t1_cnt1", a_cnt, 1);
      chk("t1_valid", a_if.resp_valid_o, 1);
      chk("t1_data", a_if.resp_data_o, 32'hFFFF_FF80);
      chk("t1_mis", a_if.resp_misalign_o, 0);
      step(); #1;
      chk("t1_empty", a_empty, 1);
      chk("t1_valid_off", a_if.resp_valid_o, 0);

      // store, HALF@1, HALF@3, unknown size
      step(); a_req(1, MEM_ACCESS_WORD, 2'd0);
      step(); a_req(0, MEM_ACCESS_HALF, 2'd1);
      step(); a_req(0, MEM_ACCESS_HALF, 2'd3);
      step(); a_req(0, 3'd7, 2'd0);
      step(); #1;
      chk("mix_cnt4", a_cnt, 4);
      chk("mix_ready0", a_if.req_ready_o, 0);
      step(); a_rv(32'h0080_0100); #1;
      chk("st_valid", a_if.resp_valid_o, 1);
      chk("st_we", a_if.resp_we_o, 1);
      chk("st_data", a_if.resp_data_o, 0);
      step(); a_rv(32'h0080_0100); #1;
      chk("lh1_we", a_if.resp_we_o, 0);
      chk("lh1_data", a_if.resp_data_o, 32'hFFFF_8001);
      chk("lh1_mis", a_if.resp_misalign_o, 0);
      step(); a_rv(32'h0080_0100); #1;
      chk("lh3_valid", a_if.resp_valid_o, 1);
      chk("lh3_mis", a_if.resp_misalign_o, 1);
      chk("lh3_data", a_if.resp_data_o, 0);
      step(); a_rv(32'h0080_0100); #1;
      chk("unk_valid", a_if.resp_valid_o, 1);
      chk("unk_mis", a_if.resp_misalign_o, 0);
      chk("unk_data", a_if.resp_data_o, 0);
      step(); #1;
      chk("mix_empty", a_empty, 1);

      // fill, pop, push+pop at 3 entries, drain across wrap
      for (int i = 0; i < 4; i++) begin
         step(); a_req(0, MEM_ACCESS_UBYTE, 2'(i));
      end
      step(); #1;
      chk("full_cnt", a_cnt, 4);
      chk("full_ready", a_if.req_ready_o, 0);
      step(); a_rv(32'h4433_2211); #1;
      chk("fifo_d0", a_if.resp_data_o, 32'h11);
      step(); a_req(0, MEM_ACCESS_UBYTE, 2'd0);
      a_rv(32'h4433_2211); #1;
      chk("fifo_d1", a_if.resp_data_o, 32'h22);
      chk("fifo_cnt3", a_cnt, 3);
      step(); a_rv(32'h4433_2211); #1;
      chk("pushpop_cnt", a_cnt, 3);
      chk("fifo_d2", a_if.resp_data_o, 32'h33);
      step(); a_rv(32'h4433_2211); #1;
      chk("fifo_d3", a_if.resp_data_o, 32'h44);
      step(); a_rv(32'h4433_2211); #1;
      chk("fifo_wrap", a_if.resp_data_o, 32'h11);
      step(); #1;
      chk("fifo_empty", a_empty, 1);

      // kill with two pending plus one pushed in the kill cycle
      step(); a_req(0, MEM_ACCESS_WORD, 2'd0);
      step(); a_req(0, MEM_ACCESS_WORD, 2'd0);
      step(); a_req(0, MEM_ACCESS_WORD, 2'd0); a_kill = 1;
      for (int i = 0; i < 3; i++) begin
         step(); a_rv(32'h1234_5678); #1;
         chk("kill_valid", a_if.resp_valid_o, 0);
      end
      step(); #1;
      chk("kill_empty", a_empty, 1);
      step(); a_req(0, MEM_ACCESS_WORD, 2'd0);
      step(); a_rv(32'h1234_5678); a_kill = 1; #1;
      chk("killpop_valid", a_if.resp_valid_o, 0);
      step(); #1;
      chk("killpop_empty", a_empty, 1);

      // stray response
      step(); a_rv(32'hDEAD_BEEF); #1;
      chk("stray_err", a_err, 1);
      chk("stray_valid", a_if.resp_valid_o, 0);
      step(); #1;
      chk("stray_err_off", a_err, 0);
      chk("stray_cnt", a_cnt, 0);

      // XLEN=64 extraction
      step(); b_req(MEM_ACCESS_UWORD, 3'd4);
      step(); b_req(MEM_ACCESS_WORD, 3'd2);
      step(); b_req(MEM_ACCESS_WORD, 3'd4);
      step(); b_req(MEM_ACCESS_DWORD, 3'd0);
      step(); #1;
      chk("b_cnt4", b_cnt, 4);
      step(); b_if.data_rvalid_i = 1;
      b_if.data_rdata_i = 64'h8000_0001_1234_5678; #1;
      chk("b_lwu", b_if.resp_data_o, 64'h0000_0000_8000_0001);
      step(); b_if.data_rvalid_i = 1; #1;
      chk("b_lw2_mis", b_if.resp_misalign_o, 1);
      chk("b_lw2_data", b_if.resp_data_o, 0);
      step(); b_if.data_rvalid_i = 1; #1;
      chk("b_lw4", b_if.resp_data_o, 64'hFFFF_FFFF_8000_0001);
      step(); b_if.data_rvalid_i = 1; #1;
      chk("b_ld", b_if.resp_data_o, 64'h8000_0001_1234_5678);
      step(); #1;
      chk("b_empty", b_empty, 1);

      // registered response path
      step(); c_req(MEM_ACCESS_UHALF, 2'd2);
      step(); c_if.data_rvalid_i = 1;
      c_if.data_rdata_i = 32'hABCD_1234; #1;
      chk("c_lat0", c_if.resp_valid_o, 0);
      step(); #1;
      chk("c_valid", c_if.resp_valid_o, 1);
      chk("c_data", c_if.resp_data_o, 32'h0000_ABCD);
      step(); #1;
      chk("c_valid_off", c_if.resp_valid_o, 0);
      step(); c_req(MEM_ACCESS_WORD, 2'd0);
      step(); c_if.data_rvalid_i = 1; c_kill = 1;
      step(); #1;
      chk("c_kill_valid", c_if.resp_valid_o, 0);
      chk("c_kill_empty", c_empty, 1);

      // reset mid-burst
      step(); c_req(MEM_ACCESS_UBYTE, 2'd0);
      step(); c_req(MEM_ACCESS_UBYTE, 2'd1);
      c_if.data_rvalid_i = 1; c_if.data_rdata_i = 32'h0000_00F0;
      step(); #1;
      chk("c_burst_valid", c_if.resp_valid_o, 1);
      chk("c_burst_data", c_if.resp_data_o, 32'hF0);
      chk("c_burst_cnt", c_cnt, 1);
      #1 rst_n = 0;
      #1;
      chk("c_arst_valid", c_if.resp_valid_o, 0);
      chk("c_arst_data", c_if.resp_data_o, 0);
      chk("c_arst_cnt", c_cnt, 0);
      chk("c_arst_empty", c_empty, 1);
      chk("c_arst_ready", c_if.req_ready_o, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
